uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, RX FIFO entries; power of two, at least 2.
REQ-002 Parameter OVERSAMPLE, default 16, sample ticks per bit; even, at least 4.
REQ-003 Parameter DIV_W, default 16, width of the baud divisor.
REQ-004 Parameter TIMEOUT_CHARS, default 4, idle character times before receive timeout.
REQ-005 Port clk, input, 1, single clock for the whole block.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port rx_i, input, 1, asynchronous serial receive line, idle high.
REQ-008 Port baud_div_i, input, DIV_W, produces one sample tick every baud_div_i+1 clocks.
REQ-009 Port data_bits_i, input, 2, selects word length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-010 Port parity_en_i / parity_odd_i / stop2_i, input, 1 each: parity enable, odd parity select, two stop bits.
REQ-011 Port fifo_clr_i / clr_overrun_i, input, 1 each: synchronous FIFO clear, overrun flag clear.
REQ-012 Port thresh_i, input, $clog2(FIFO_DEPTH)+1, interrupt level threshold; 0 disables the level interrupt.
REQ-013 Port rd_valid_o / rd_ready_i, output / input, 1 each: read handshake.
REQ-014 Port rd_data_o, output, 8, data at the FIFO head; unused upper bits read as 0.
REQ-015 Port rd_err_o, output, 3, head entry errors {break, framing, parity}.
REQ-016 Port level_o, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-017 Port overrun_o / timeout_o / irq_o, output, 1 each: sticky overrun, receive timeout, interrupt.

Function
REQ-018 rx_i SHALL pass through a 2-flop synchronizer before any use.
REQ-019 The tick counter SHALL count 0..baud_div_i, pulse tick at the terminal count, then wrap to 0; baud_div_i=0 gives a tick every clock.
REQ-020 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-021 IDLE->START SHALL occur when the synchronized rx is 0; the tick phase counter is zeroed, and data_bits/parity/stop2 are latched for the frame.
REQ-022 START SHALL resample at tick OVERSAMPLE/2: rx=1 is a false start and returns the FSM to IDLE with no push; rx=0 moves the FSM to DATA.
REQ-023 DATA SHALL sample every OVERSAMPLE ticks (mid-bit), LSB first, for the latched number of bits, then move to PARITY if enabled, else to STOP.
REQ-024 Parity check: even parity requires XOR of the data bits and the parity bit to be 0, odd parity requires 1; a mismatch sets the parity error.
REQ-025 STOP SHALL sample one stop bit, or two if stop2; any sampled 0 sets the framing error.
REQ-026 Break SHALL be flagged when all data, parity and first-stop samples are 0; the entry is stored as data 0x00 with break and framing set.
REQ-027 The frame SHALL be pushed one clock after the final stop sample; the FSM then enters BRK_WAIT if break was flagged, else IDLE.
REQ-028 BRK_WAIT SHALL remain until the synchronized rx is 1, then go to IDLE.
REQ-029 The FIFO SHALL be first-word-fall-through: rd_valid_o = !empty, a pop occurs on rd_valid_o && rd_ready_i, and level_o updates the cycle after the push or pop.
REQ-030 A push while full with no pop SHALL drop the frame and set overrun_o; a push and pop in the same cycle while full SHALL both succeed.
REQ-031 overrun_o SHALL stay set until clr_overrun_i is asserted; if set and clear occur in the same cycle, set wins.
REQ-032 fifo_clr_i SHALL zero both pointers and level and clear timeout_o; it overrides a same-cycle push or pop and does not disturb the FSM.
REQ-033 The timeout counter SHALL count ticks, restarting on any push, pop or clear, or while the FIFO is empty.
REQ-034 timeout_o SHALL set when the count reaches TIMEOUT_CHARS*10*OVERSAMPLE with level_o>0, and clear on the next pop or clear.
REQ-035 irq_o SHALL be registered and equal (thresh_i!=0 && level_o>=thresh_i) || timeout_o.

Reset
REQ-036 While rst is low: all outputs 0, synchronizer flops 1, FSM in IDLE, counters 0, FIFO empty.
REQ-037 A frame in progress when rst asserts SHALL be discarded; after release the block SHALL wait for a new start edge.

Structure
REQ-038 Package uart_pkg SHALL hold the FSM state enum, the data_bits encoding, the rd_err_o bit indices and the parameter defaults.
REQ-039 The FIFO SHALL be a separate sub-module uart_sync_fifo, parametrised in width and depth, instantiated here with width 11.

Verification
REQ-040 baud_div_i=3, 8N1, send 0xA5 -> one entry 0xA5, err 000, pushed 1 clock after the stop sample.
REQ-041 7E1, send 0x35 with the parity bit inverted -> entry 0x35, err 001.
REQ-042 rx_i low for 3 ticks then high -> no push; FSM back in IDLE.
REQ-043 FIFO_DEPTH=4, send 5 frames with no reads -> level_o=4, overrun_o=1, first 4 entries read back in order.
REQ-044 rx_i held low for 2 frame times -> exactly one entry 0x00, err 110; no further push until rx_i returns high.
REQ-045 One frame received, thresh_i=8, then 640 idle ticks -> timeout_o=1 and irq_o=1; one pop -> both return to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver with RX FIFO.
//   - parameter defaults for uart_rx_fifo
//   - receive FSM state encoding
//   - data_bits_i word-length encoding
//   - bit positions of the error field stored with every FIFO entry
package uart_pkg;

  localparam int DEF_FIFO_DEPTH    = 16;
  localparam int DEF_OVERSAMPLE    = 16;
  localparam int DEF_DIV_W         = 16;
  localparam int DEF_TIMEOUT_CHARS = 4;

  // One FIFO entry: {err[2:0], data[7:0]}
  localparam int FIFO_WIDTH = 11;

  // data_bits_i encoding
  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;

  // Bit indices inside rd_err_o
  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_BRK = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_e;

  // Index of the last data bit for a given word-length code.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] db);
    logic [2:0] idx;
    case (db)
      DB_5:    idx = 3'd4;
      DB_6:    idx = 3'd5;
      DB_7:    idx = 3'd6;
      DB_8:    idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

  // Build a FIFO entry from its error flags and data byte.
  function automatic logic [FIFO_WIDTH-1:0] pack_entry(input logic brk, input logic frm,
                                                       input logic par, input logic [7:0] data);
    logic [2:0] err;
    err          = 3'b000;
    err[ERR_BRK] = brk;
    err[ERR_FRM] = frm;
    err[ERR_PAR] = par;
    return {err, data};
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clr             synchronous clear; overrides push and pop
//   push, push_data write request and data
//   pop             read request (ignored when empty)
//   head            entry at the head, zero while empty
//   empty           no entries stored
//   level           current occupancy
//   level_next      occupancy after this clock edge
//   push_ok, pop_ok push / pop accepted this cycle
//   overflow        push refused because the FIFO is full and not popping
module uart_sync_fifo #(
  parameter int  WIDTH = 11,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [LW-1:0]    level,
  output logic [LW-1:0]    level_next,
  output logic             push_ok,
  output logic             pop_ok,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             full_s;

  assign empty    = (level_r == LW'(0));
  assign full_s   = (level_r == LW'(DEPTH));
  assign pop_ok   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push && (!full_s || pop_ok);
  assign overflow = push && full_s && !pop_ok && !clr;
  assign level    = level_r;
  assign head     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Next occupancy, shared with the parent for its registered interrupt.
  always_comb begin
    level_next = level_r;
    if (clr) begin
      level_next = LW'(0);
    end else if (push_ok && !pop_ok) begin
      level_next = level_r + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_next = level_r - LW'(1);
    end else begin
      level_next = level_r;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else if (clr) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else begin
      if (push_ok) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_next;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (5-8 data bits, optional parity, 1/2 stop bits,
// break detection) feeding a first-word-fall-through receive FIFO with
// overrun, receive-timeout and level interrupt.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   rx_i                           asynchronous serial input, idle high
//   baud_div_i                     sample tick every baud_div_i+1 clocks
//   data_bits_i                    00=5 .. 11=8 data bits
//   parity_en_i, parity_odd_i      parity enable / odd select
//   stop2_i                        two stop bits
//   fifo_clr_i, clr_overrun_i      FIFO clear, overrun flag clear
//   thresh_i                       level interrupt threshold (0 = off)
//   rd_valid_o, rd_ready_i         read handshake
//   rd_data_o, rd_err_o            head data and {break, framing, parity}
//   level_o                        FIFO occupancy
//   overrun_o, timeout_o, irq_o    status and interrupt
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int  FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int  OVERSAMPLE    = DEF_OVERSAMPLE,
  parameter int  DIV_W         = DEF_DIV_W,
  parameter int  TIMEOUT_CHARS = DEF_TIMEOUT_CHARS,
  localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic [1:0]       data_bits_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             stop2_i,
  input  logic             fifo_clr_i,
  input  logic             clr_overrun_i,
  input  logic [LW-1:0]    thresh_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [7:0]       rd_data_o,
  output logic [2:0]       rd_err_o,
  output logic [LW-1:0]    level_o,
  output logic             overrun_o,
  output logic             timeout_o,
  output logic             irq_o
);

  localparam int PH_W     = $clog2(OVERSAMPLE);
  localparam int TO_LIMIT = TIMEOUT_CHARS * 10 * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  // Synchronizer and baud tick
  logic             sync1_r, sync2_r, rx_s;
  logic [DIV_W-1:0] tick_cnt_r;
  logic             tick_s;

  // Receive FSM
  rx_state_e             state_r;
  logic [PH_W-1:0]       phase_r;
  logic [2:0]            bit_cnt_r;
  logic [7:0]            shift_r;
  logic                  par_acc_r, zero_r, perr_r, ferr_r, brk_r, stop_cnt_r;
  logic [1:0]            db_r;
  logic                  pe_r, po_r, s2_r;
  logic                  push_r;
  logic [FIFO_WIDTH-1:0] push_word_r;
  logic                  mid_bit_s, mid_start_s;
  logic                  frame_brk_s, frame_ferr_s, last_stop_s;
  logic [FIFO_WIDTH-1:0] frame_word_s;

  // FIFO and status
  logic [FIFO_WIDTH-1:0] head_s;
  logic                  empty_s, push_ok_s, pop_ok_s, overflow_s;
  logic [LW-1:0]         level_s, level_next_s;
  logic [TO_W-1:0]       to_cnt_r;
  logic                  to_hit_s, timeout_r, timeout_next_s;
  logic                  overrun_r, irq_r, irq_next_s;

  assign rx_s        = sync2_r;
  assign tick_s      = (tick_cnt_r >= baud_div_i);
  assign mid_start_s = tick_s && (phase_r == PH_W'(OVERSAMPLE / 2 - 1));
  assign mid_bit_s   = tick_s && (phase_r == PH_W'(OVERSAMPLE - 1));

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_i;
      sync2_r <= sync1_r;
    end
  end

  // Free-running sample tick divider; >= lets a shrinking divisor wrap at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= DIV_W'(0);
    end else if (tick_s) begin
      tick_cnt_r <= DIV_W'(0);
    end else begin
      tick_cnt_r <= tick_cnt_r + DIV_W'(1);
    end
  end

  // Result of the stop sample taken this cycle and the entry it would produce.
  always_comb begin
    frame_ferr_s = ferr_r | ~rx_s;
    last_stop_s  = stop_cnt_r | ~s2_r;
    if (stop_cnt_r) begin
      frame_brk_s = brk_r;
    end else begin
      frame_brk_s = zero_r & ~rx_s;
    end
    if (frame_brk_s) begin
      frame_word_s = pack_entry(1'b1, 1'b1, 1'b0, 8'h00);
    end else begin
      frame_word_s = pack_entry(1'b0, frame_ferr_s, perr_r, shift_r);
    end
  end

  // Receive FSM: oversampled frame decoding with a registered push strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      phase_r     <= PH_W'(0);
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      par_acc_r   <= 1'b0;
      zero_r      <= 1'b0;
      perr_r      <= 1'b0;
      ferr_r      <= 1'b0;
      brk_r       <= 1'b0;
      stop_cnt_r  <= 1'b0;
      db_r        <= DB_8;
      pe_r        <= 1'b0;
      po_r        <= 1'b0;
      s2_r        <= 1'b0;
      push_r      <= 1'b0;
      push_word_r <= {FIFO_WIDTH{1'b0}};
    end else begin
      push_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) begin
            state_r    <= ST_START;
            phase_r    <= PH_W'(0);
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            par_acc_r  <= 1'b0;
            zero_r     <= 1'b1;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            brk_r      <= 1'b0;
            stop_cnt_r <= 1'b0;
            db_r       <= data_bits_i;
            pe_r       <= parity_en_i;
            po_r       <= parity_odd_i;
            s2_r       <= stop2_i;
          end
        end
        ST_START: begin
          if (mid_start_s) begin
            phase_r <= PH_W'(0);
            // A high line at mid start bit is a glitch, not a frame.
            state_r <= rx_s ? ST_IDLE : ST_DATA;
          end else if (tick_s) begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        ST_DATA: begin
          if (mid_bit_s) begin
            phase_r            <= PH_W'(0);
            shift_r[bit_cnt_r] <= rx_s;
            par_acc_r          <= par_acc_r ^ rx_s;
            zero_r             <= zero_r & ~rx_s;
            if (bit_cnt_r == last_bit_idx(db_r)) begin
              state_r <= pe_r ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else if (tick_s) begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        ST_PARITY: begin
          if (mid_bit_s) begin
            phase_r <= PH_W'(0);
            // Total XOR must equal 1 for odd parity, 0 for even.
            perr_r  <= par_acc_r ^ rx_s ^ po_r;
            zero_r  <= zero_r & ~rx_s;
            state_r <= ST_STOP;
          end else if (tick_s) begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        ST_STOP: begin
          if (mid_bit_s) begin
            phase_r <= PH_W'(0);
            ferr_r  <= frame_ferr_s;
            brk_r   <= frame_brk_s;
            if (last_stop_s) begin
              push_r      <= 1'b1;
              push_word_r <= frame_word_s;
              state_r     <= frame_brk_s ? ST_BRK_WAIT : ST_IDLE;
            end else begin
              stop_cnt_r <= 1'b1;
            end
          end else if (tick_s) begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        ST_BRK_WAIT: begin
          if (rx_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (fifo_clr_i),
    .push       (push_r),
    .push_data  (push_word_r),
    .pop        (rd_ready_i),
    .head       (head_s),
    .empty      (empty_s),
    .level      (level_s),
    .level_next (level_next_s),
    .push_ok    (push_ok_s),
    .pop_ok     (pop_ok_s),
    .overflow   (overflow_s)
  );

  assign to_hit_s = (to_cnt_r == TO_W'(TO_LIMIT)) && !empty_s;

  // Idle-tick counter for the receive timeout; saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_r <= TO_W'(0);
    end else if (push_ok_s || pop_ok_s || fifo_clr_i || empty_s) begin
      to_cnt_r <= TO_W'(0);
    end else if (tick_s && (to_cnt_r != TO_W'(TO_LIMIT))) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  // Next timeout and interrupt values, so irq_o tracks level_o in the same cycle.
  always_comb begin
    if (fifo_clr_i || pop_ok_s) begin
      timeout_next_s = 1'b0;
    end else if (to_hit_s) begin
      timeout_next_s = 1'b1;
    end else begin
      timeout_next_s = timeout_r;
    end
    irq_next_s = ((thresh_i != LW'(0)) && (level_next_s >= thresh_i)) || timeout_next_s;
  end

  // Status registers; a new overrun wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_r <= 1'b0;
      timeout_r <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      if (overflow_s) begin
        overrun_r <= 1'b1;
      end else if (clr_overrun_i) begin
        overrun_r <= 1'b0;
      end
      timeout_r <= timeout_next_s;
      irq_r     <= irq_next_s;
    end
  end

  assign rd_valid_o = !empty_s;
  assign rd_data_o  = head_s[7:0];
  assign rd_err_o   = head_s[10:8];
  assign level_o    = level_s;
  assign overrun_o  = overrun_r;
  assign timeout_o  = timeout_r;
  assign irq_o      = irq_r;

endmodule
